muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit for the processor datapath. It consumes the two source operands read from the register file (RD1/RD2) plus the destination index. It produces a registered result with a one-cycle `done` strobe that drives the register-file write port (WD3/A3/WE3) for M-extension instructions. One operation is in flight at a time, and every operation takes a fixed latency, so the control unit can stall with simple logic.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count of the shift loop; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only when the unit is idle
- funct3  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  input  32  operand A (RD1)
- rs2_val  input  32  operand B (RD2)
- rd_in  input  5  destination register index
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle strobe; result/rd_out valid; drives WE3
- result  output  32  operation result; drives WD3
- rd_out  output  5  captured rd_in; drives A3

## Operation
States:
- IDLE: on start=1, go to CALC, counter=0.
  - Capture: funct3, rd_in, operand magnitudes, sign flags, special-case flags.
  - start is ignored in every other state.
- CALC: one iteration per edge. At the edge where counter==31, go to FIX; otherwise counter+1.
- FIX: apply sign correction and result select; load result and rd_out; go to DONE.
- DONE: done=1 for this cycle only; next edge returns to IDLE.

Signedness:
- MUL, MULH, DIV, REM treat both operands as signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU, DIVU, REMU treat both operands as unsigned.
- Signed operands are converted to magnitude before iterating.

Multiply:
- Unsigned shift-add into a 64-bit product.
- Negate the 64-bit product if exactly one signed operand is negative.
- MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].

Divide:
- Restoring division with a 33-bit partial remainder; produces quotient Q and remainder R.
- Signed ops: Q is negated if the operand signs differ; R takes the dividend's sign.

Special cases are flagged at capture. The datapath still runs the full 32 iterations, and FIX overrides the result:
- Divisor 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1_val.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.

Hold behaviour:
- result and rd_out hold their values until the next FIX.
- Input ports may change freely after the start edge.

Reset values:
- state IDLE, counter 0.
- busy 0, done 0, result 0, rd_out 0.
- Reset mid-operation aborts the operation; no done is produced.

## Timing
- Edge E0: start sampled in IDLE. busy=1 from just after E0.
- E1..E32: iterations. E32 moves the state to FIX.
- E33: FIX loads result and rd_out. done=1 during the cycle after E33.
- E34: return to IDLE; done=0, busy=0.
- Latency: done is asserted 33 cycles after the start edge, identical for all funct3 values and special cases.
- busy is high through the done cycle. The earliest accepted back-to-back start is at E34+1, i.e. the first edge sampled in IDLE.
- Register-file writeback: WE3=done, A3=rd_out, WD3=result, all aligned in the same cycle.

## Test plan
1. MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; MULH 0x80000000 × 0x80000000 → 0x40000000. Check done exactly 33 cycles after start, for one cycle; rd_out equals rd_in.
2. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MUL 0x12345678 × 0 → 0.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
4. Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 0xFFFFFFFF/0 → 0xFFFFFFFF. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0. Each case completes with the 33-cycle latency.
5. start pulsed while busy at E5 and E33 → ignored: result unchanged, exactly one done. start held high continuously → operations accepted every 35 cycles.
6. reset asserted asynchronously mid-CALC (e.g. iteration 10) → busy, done and result read 0 before the next edge, and no done follows. A subsequent DIVU 100/7 returns 14 with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, fixed 33-cycle latency.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start             request, sampled only in IDLE
//   funct3            0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1_val, rs2_val  operands (RD1/RD2)
//   rd_in             destination index
//   busy              high whenever not IDLE
//   done              one-cycle strobe (WE3); result (WD3) / rd_out (A3) valid
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CNT_W = $clog2(ITER);
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F_MUL = 3'd0;
  localparam logic [2:0] F_DIV = 3'd4;
  localparam logic [2:0] F_REM = 3'd6;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Operand decode: signedness, magnitudes and special-case flags
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_signed = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
               (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd0) || (funct3 == 3'd1) ||
               (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed & rs1_val[XLEN-1];
    b_neg    = b_signed & rs2_val[XLEN-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
  end

  // One iteration of each algorithm; acc_q holds {hi,lo} product or dividend/quotient
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_sh, div_diff;
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    div_sh   = {rem_q, acc_q[XLEN-1]};
    div_diff = div_sh - {2'b00, b_mag_q};
  end

  // Result select with sign correction and special-case override
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rmd, fix_val;
  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (!op_q[2]) begin
      fix_val = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end else if (div0_q) begin
      fix_val = op_q[1] ? rs1_q : '1;
    end else if (ovf_q) begin
      fix_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      fix_val = op_q[1] ? rmd : quo;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    rs1_d     = rs1_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = funct3;
          rd_d      = rd_in;
          a_mag_d   = a_mag;
          b_mag_d   = b_mag;
          rs1_d     = rs1_val;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (rs2_val == '0);
          ovf_d     = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                      (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);
          acc_d     = funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          rem_d     = '0;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          // Restoring step: keep the subtraction only if it did not go negative
          if (!div_diff[XLEN+1]) begin
            rem_d = div_diff[XLEN:0];
            acc_d = {acc_q[PW-1:XLEN], acc_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = div_sh[XLEN:0];
            acc_d = {acc_q[PW-1:XLEN], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        result_d = fix_val;
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      rs1_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      rs1_q     <= rs1_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
